// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle datapath.
// Sequences datapath enables per opcode and flags unsupported opcodes.
module multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [5:0] opcode,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       IllegalOp,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADDR = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC    = 4'd7,
        S_RCOMP   = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10
    } state_e;

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= S_RESET;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = S_FETCH;
        illegal_d = illegal_q;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADDR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            // IR is frozen since FETCH, so the opcode still names LW or SW
            S_MEMADDR: begin
                if (opcode == OP_LW)      state_d = S_MEMRD;
                else if (opcode == OP_SW) state_d = S_MEMWR;
                else                      state_d = S_FETCH;
            end
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_RCOMP;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUSrcB = 2'b01;
            end
            S_DECODE:  ALUSrcB = 2'b11;
            S_MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_RCOMP: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            default: ;
        endcase
    end

    assign IllegalOp = illegal_q;
    assign state     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: path-level model plus directed state traces.
module tb_multicycle_control;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic [5:0] opcode = 6'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;

    int checks = 0;
    int failures = 0;

    multicycle_control dut (
        .Clk(Clk), .Rst(Rst), .opcode(opcode),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .IllegalOp(IllegalOp), .state(state)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca;
        logic [1:0] srcb, aluop, pcsrc;
    } ctl_t;

    // Control word each state must present, as listed state by state
    function automatic ctl_t exp_ctl(input int s);
        ctl_t c;
        c = '0;
        case (s)
            1: begin
                c.mrd = 1; c.irw = 1; c.pcw = 1; c.srcb = 2'b01;
            end
            2: c.srcb = 2'b11;
            3: begin c.srca = 1; c.srcb = 2'b10; end
            4: begin c.mrd = 1; c.iord = 1; end
            5: begin c.rwr = 1; c.m2r = 1; end
            6: begin c.mwr = 1; c.iord = 1; end
            7: begin c.srca = 1; c.aluop = 2'b10; end
            8: begin c.rwr = 1; c.rdst = 1; end
            9: begin
                c.srca = 1; c.aluop = 2'b01;
                c.pcwc = 1; c.pcsrc = 2'b01;
            end
            10: begin c.pcw = 1; c.pcsrc = 2'b10; end
            default: c = '0;
        endcase
        return c;
    endfunction

    ctl_t act;
    assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                  PCSource};

    // Path model: every instruction is FETCH, DECODE, then an opcode tail
    int m_state = 0;
    bit m_ill = 0;
    int tail[$];

    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            m_state = 0;
            m_ill   = 0;
            tail.delete();
        end else begin
            if (m_state == 2) begin
                case (opcode)
                    6'b100011: tail = {3, 4, 5};
                    6'b101011: tail = {3, 6};
                    6'b000000: tail = {7, 8};
                    6'b000100: tail = {9};
                    6'b000010: tail = {10};
                    default: begin
                        tail.delete();
                        m_ill = 1;
                    end
                endcase
            end
            if (m_state == 1)          m_state = 2;
            else if (tail.size() != 0) m_state = tail.pop_front();
            else                       m_state = 1;
        end
    end

    always @(negedge Clk) begin
        checks++;
        if (state !== 4'(m_state)) begin
            failures++;
            $display("FAIL model_state actual=%0d required=%0d", state, m_state);
        end
        checks++;
        if (act !== exp_ctl(m_state)) begin
            failures++;
            $display("FAIL model_ctl st=%0d actual=%h required=%h",
                     m_state, act, exp_ctl(m_state));
        end
        checks++;
        if (IllegalOp !== m_ill) begin
            failures++;
            $display("FAIL model_illegal actual=%b required=%b", IllegalOp, m_ill);
        end
        checks++;
        if ((MemRead && MemWrite) || (PCWrite && PCWriteCond)) begin
            failures++;
            $display("FAIL exclusive_strobes actual=%b%b%b%b required=no_pair",
                     MemRead, MemWrite, PCWrite, PCWriteCond);
        end
    end

    task automatic chk(input string name, input logic [15:0] a,
                       input logic [15:0] r);
        checks++;
        if (a !== r) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, a, r);
        end
    endtask

    // Called at a negedge in FETCH; leaves at the next FETCH
    task automatic run(input logic [5:0] op, input logic [19:0] seq,
                       input int len);
        logic [3:0] e;
        opcode = op;
        for (int i = 0; i < len; i++) begin
            e = seq[19-4*i -: 4];
            chk($sformatf("trace_op%b_%0d", op, i), 16'(state), 16'(e));
            @(negedge Clk);
        end
    endtask

    task automatic release_rst();
        Rst = 1'b1;
        @(negedge Clk);
        chk("post_rst_state", 16'(state), 16'd1);
        chk("post_rst_ctl", act, 16'b1001_0100_0001_0000);
    endtask

    initial begin
        Rst = 1'b0;
        opcode = 6'b0;
        repeat (2) @(negedge Clk);
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_ctl", act, 16'h0);
        chk("rst_illegal", 16'(IllegalOp), 16'd0);
        release_rst();
        run(6'b100011, 20'h12345, 5);
        run(6'b000000, 20'h12780, 4);
        run(6'b000100, 20'h12900, 3);
        run(6'b000010, 20'h12A00, 3);
        run(6'b101011, 20'h12360, 4);
        run(6'b111111, 20'h12000, 2);
        chk("illegal_set", 16'(IllegalOp), 16'd1);
        chk("after_illegal_state", 16'(state), 16'd1);
        run(6'b000100, 20'h12900, 3);
        chk("illegal_sticky", 16'(IllegalOp), 16'd1);
        opcode = 6'b000000;
        repeat (2) @(negedge Clk);
        chk("pre_abort_state", 16'(state), 16'd7);
        #2 Rst = 1'b0;
        #1;
        chk("abort_state", 16'(state), 16'd0);
        chk("abort_illegal", 16'(IllegalOp), 16'd0);
        chk("abort_ctl", act, 16'h0);
        repeat (2) @(negedge Clk);
        release_rst();
        run(6'b100011, 20'h12345, 5);
        run(6'b101011, 20'h12360, 4);
        chk("illegal_clear", 16'(IllegalOp), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle datapath.
- Decodes the instruction opcode and sequences datapath enables over 3–5 cycles per instruction.
- Drives the 2-bit ALUOp consumed by the ALU control block:
  - 00 = add
  - 01 = subtract
  - 10 = decode from funct
- Sits between the instruction register and every datapath mux/enable.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word opcode
- OP_SW, 6'b101011, store word opcode
- OP_BEQ, 6'b000100, branch-equal opcode
- OP_J, 6'b000010, jump opcode

Ports:
- Clk  in  1  clock, rising edge
- Rst  in  1  asynchronous, active-low reset
- opcode  in  6  instruction[31:26] from the instruction register
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load qualified by ALU Zero (combined in datapath)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  register write data select: 1 = MDR, 0 = ALUOut
- RegDst  out  1  destination select: 1 = rd, 0 = rt
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = register A
- ALUSrcB  out  2  ALU B select: 00 = reg B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- ALUOp  out  2  to ALU control
- PCSource  out  2  PC select: 00 = ALU, 01 = ALUOut, 10 = jump target
- IllegalOp  out  1  sticky unsupported-opcode flag
- state  out  4  current state, debug

Behaviour:
- Moore machine. All outputs except IllegalOp are decoded combinationally from the 4-bit state register only.
- Every output not listed for a state is 0.

States:
- RESET(0): all outputs 0. Exits unconditionally to FETCH on the first rising edge after Rst goes high.
- FETCH(1): MemRead, IRWrite, PCWrite=1; IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. Next: DECODE.
- DECODE(2): ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next is selected by opcode:
  - LW/SW -> MEMADDR
  - RTYPE -> EXEC
  - BEQ -> BRANCH
  - J -> JUMP
  - any other value -> FETCH, with IllegalOp set
- MEMADDR(3): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: MEMRD for LW, MEMWR for SW.
  - Opcode is re-read here and must be unchanged (IRWrite=0 since FETCH).
- MEMRD(4): MemRead=1, IorD=1. Next: MEMWB.
- MEMWB(5): RegWrite=1, MemtoReg=1, RegDst=0. Next: FETCH.
- MEMWR(6): MemWrite=1, IorD=1. Next: FETCH.
- EXEC(7): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: RCOMP.
- RCOMP(8): RegWrite=1, RegDst=1, MemtoReg=0. Next: FETCH.
- BRANCH(9): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next: FETCH.
- JUMP(10): PCWrite=1, PCSource=10. Next: FETCH.
- Encodings 11–15 are unreachable; if entered, next state is FETCH and outputs are all 0.

Latency (cycles, FETCH to the last state inclusive):
- LW 5; SW 4; R-type 4; BEQ 3; J 3.
- A new FETCH follows immediately, with no idle cycles.

IllegalOp:
- Register, cleared only by Rst.
- Set on the rising edge that leaves DECODE with an unsupported opcode; remains 1 thereafter.
- The FSM keeps running.

Reset:
- Rst=0 forces state=RESET and IllegalOp=0 immediately, asynchronously, at any point including mid-instruction.
- All outputs read 0 while Rst=0.
- An interrupted instruction is abandoned, not resumed.

Other rules:
- MemRead and MemWrite are never both 1.
- PCWrite and PCWriteCond are never both 1.
- RegWrite is 1 only in MEMWB and RCOMP.

Test Plan:
1. Rst=0 for 2 cycles, then 1 -> state=0 with all outputs 0 during reset; state=1, MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01 one edge after release.
2. opcode=6'b100011 (LW) held -> states 1,2,3,4,5,1. ALUOp=00 in 1/2/3; IorD=1 in 4 and 5's predecessor; RegWrite=1, MemtoReg=1 in 5 only.
3. opcode=6'b000000 (R-type) -> states 1,2,7,8,1. ALUOp=10 in state 7; RegDst=1, RegWrite=1 in state 8.
4. opcode=6'b000100 then 6'b000010 -> BEQ: 1,2,9 with ALUOp=01, PCWriteCond=1, PCSource=01. Then J: 1,2,10 with PCWrite=1, PCSource=10.
5. opcode=6'b101011 (SW) -> states 1,2,3,6,1. MemWrite=1 only in 6; RegWrite never 1.
6. opcode=6'b111111 -> 1,2,1 with IllegalOp=1 from the DECODE exit onward. Then drive Rst=0 mid-state 7 of a following R-type -> state=0 and IllegalOp=0 before the next clock edge.
